// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with arbitrary depth, programmable almost-full/almost-empty
// levels, occupancy count, synchronous flush and registered handshake flags.
module fifo_sync_param #(
  parameter  int FIFO_WIDTH = 16,
  parameter  int FIFO_DEPTH = 8,
  parameter  int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter  int AE_LEVEL   = 1,
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CW-1:0]         count
);

  localparam int              PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0]   LAST    = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]   AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0]   AE_C    = CW'(AE_LEVEL);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  rd_ok, wr_ok;

  // A full FIFO still takes a write when the same edge pops the head.
  assign rd_ok = rd_en && (count != '0);
  assign wr_ok = wr_en && ((count != DEPTH_C) || rd_ok);

  // Explicit wrap so non-power-of-two depths never index past the array.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk)
    if (rst_n && !flush && wr_ok) mem[wr_ptr] <= data_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_ok;
      overflow  <= wr_en && !wr_ok;
      underflow <= rd_en && !rd_ok;
      if (wr_ok) wr_ptr <= nxt(wr_ptr);
      if (rd_ok) begin
        rd_ptr   <= nxt(rd_ptr);
        data_out <= mem[rd_ptr];
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign almostfull  = (count >= AF_C) && !full;
  assign almostempty = (count <= AE_C) && !empty;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench: stimulus pushes queue-model expectations, a monitor
// compares them one cycle later; depth-8 and depth-5 instances share the clock.
module tb_fifo_sync_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n = 2'b00, flush = '0, wr_en = '0, rd_en = '0;
  logic [1:0][15:0] din = '0, dout;
  logic [1:0]       ack, ov, un, full, empty, af, ae;
  logic [3:0]       cnt0;
  logic [2:0]       cnt1;

  fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) u_d8 (
    .clk(clk), .rst_n(rst_n[0]), .flush(flush[0]), .data_in(din[0]),
    .wr_en(wr_en[0]), .rd_en(rd_en[0]), .data_out(dout[0]), .wr_ack(ack[0]),
    .overflow(ov[0]), .underflow(un[0]), .full(full[0]), .empty(empty[0]),
    .almostfull(af[0]), .almostempty(ae[0]), .count(cnt0));

  fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) u_d5 (
    .clk(clk), .rst_n(rst_n[1]), .flush(flush[1]), .data_in(din[1]),
    .wr_en(wr_en[1]), .rd_en(rd_en[1]), .data_out(dout[1]), .wr_ack(ack[1]),
    .overflow(ov[1]), .underflow(un[1]), .full(full[1]), .empty(empty[1]),
    .almostfull(af[1]), .almostempty(ae[1]), .count(cnt1));

  int errors = 0, checks = 0, cur = 0;
  int D[2]  = '{8, 5};
  int AF[2] = '{6, 4};
  int AE[2] = '{2, 1};

  typedef struct {
    logic [15:0] d;
    logic [31:0] cnt;
    logic        ack, ov, un;
    logic [3:0]  st;
  } exp_t;

  exp_t        expq[$];
  logic [15:0] mq[$];
  logic [15:0] mdout = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut%0d): got %0h expected %0h", nm, cur, act, exp);
    end
  endtask

  // {full, empty, almostfull, almostempty} from occupancy alone
  function automatic logic [3:0] status(input int n, input int c);
    logic f, e;
    f = (n == D[c]);
    e = (n == 0);
    return {f, e, (n >= AF[c]) && !f, (n <= AE[c]) && !e};
  endfunction

  function automatic logic [31:0] act_cnt();
    return (cur == 0) ? {28'b0, cnt0} : {29'b0, cnt1};
  endfunction

  function automatic logic [3:0] act_st();
    return {full[cur], empty[cur], af[cur], ae[cur]};
  endfunction

  // Drive one request at a negedge and queue what the next edge must produce.
  task automatic cycle(input bit w, input bit r, input bit f, input logic [15:0] d);
    exp_t e;
    bit   rok, wok;
    wr_en[cur] = w; rd_en[cur] = r; flush[cur] = f; din[cur] = d;
    if (f) begin
      mq.delete();
      e.ack = 0; e.ov = 0; e.un = 0;
    end else begin
      rok = r && (mq.size() != 0);
      wok = w && ((mq.size() != D[cur]) || rok);
      if (rok) mdout = mq.pop_front();
      if (wok) mq.push_back(d);
      e.ack = wok; e.ov = w && !wok; e.un = r && !rok;
    end
    e.d   = mdout;
    e.cnt = mq.size();
    e.st  = status(mq.size(), cur);
    expq.push_back(e);
    @(negedge clk);
  endtask

  // Reset asserted between edges; outputs must settle before any clock edge.
  task automatic dorst(input int c);
    cur = c;
    wr_en[c] = 0; rd_en[c] = 0; flush[c] = 0;
    rst_n[c] = 0;
    #1;
    chk("rst count", act_cnt(), 0);
    chk("rst data_out", dout[c], 0);
    chk("rst flags", {ack[c], ov[c], un[c]}, 0);
    chk("rst status", act_st(), 4'b0100);
    mq.delete();
    mdout = '0;
    @(negedge clk);
    rst_n[c] = 1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      chk("data_out", dout[cur], e.d);
      chk("count", act_cnt(), e.cnt);
      chk("wr_ack", ack[cur], e.ack);
      chk("overflow", ov[cur], e.ov);
      chk("underflow", un[cur], e.un);
      chk("status", act_st(), e.st);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 31) == 0), 16'($urandom));
  endtask

  initial begin
    @(negedge clk);
    dorst(0);
    for (int i = 1; i <= 8; i++) cycle(1, 0, 0, 16'(i));
    cycle(1, 0, 0, 16'h0009);                          // overflow at full
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 16'h0);
    cycle(0, 1, 0, 16'h0);                             // underflow at empty
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 16'(16'h10 + i));
    cycle(1, 1, 0, 16'h0020);                          // both at full
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 16'h0);
    cycle(1, 1, 0, 16'h0030);                          // both at empty
    cycle(0, 1, 0, 16'h0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 16'(16'h40 + i));
    cycle(1, 1, 1, 16'h0050);                          // flush beats wr/rd
    cycle(1, 0, 0, 16'hBEEF);
    cycle(0, 1, 0, 16'h0);
    rand_run(300);

    dorst(1);
    for (int i = 0; i < 13; i++) begin
      cycle(1, 0, 0, 16'(16'h100 + i));
      cycle(0, 1, 0, 16'h0);
    end
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 16'(16'h200 + i));
    cycle(0, 1, 0, 16'h0);
    dorst(1);
    rand_run(300);

    @(negedge clk);
    chk("scoreboard drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
